// File: rtl/ddr4_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// ddr4_cmd_sequencer : open-page DDR4 PRE/ACT/RD/WR sequencer with tRP/tRCD/BL
// Rev 1.0
// ============================================================================
module ddr4_cmd_sequencer #(
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int BL        = 8,
  parameter int TRCD      = 4,
  parameter int TRP       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic                 cke,
  output logic                 cs_n,
  output logic                 act_n,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic [ADDRWIDTH-1:0] A,
  output logic                 busy
);

  localparam int IW    = BGWIDTH + BAWIDTH;
  localparam int NBANK = 1 << IW;
  localparam int MAXT  = (TRCD > TRP) ? ((TRCD > BL) ? TRCD : BL)
                                      : ((TRP > BL) ? TRP : BL);
  localparam int CW    = $clog2(MAXT) + 1;
  localparam int RAS_B = ADDRWIDTH - 1;
  localparam int CAS_B = ADDRWIDTH - 2;
  localparam int WE_B  = ADDRWIDTH - 3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRE      = 3'd1,
    S_PRE_WAIT = 3'd2,
    S_ACT      = 3'd3,
    S_ACT_WAIT = 3'd4,
    S_CAS      = 3'd5,
    S_BURST    = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 lat_wr_q, lat_wr_d;
  logic [BGWIDTH-1:0]   lat_bg_q, lat_bg_d;
  logic [BAWIDTH-1:0]   lat_ba_q, lat_ba_d;
  logic [ADDRWIDTH-1:0] lat_row_q, lat_row_d;
  logic [COLWIDTH-1:0]  lat_col_q, lat_col_d;

  logic [NBANK-1:0]     open_q, open_d;
  logic [ADDRWIDTH-1:0] row_tbl_q [NBANK];
  logic [ADDRWIDTH-1:0] row_tbl_d [NBANK];

  logic                 cke_q, cke_d;
  logic                 cs_n_q, cs_n_d;
  logic                 act_n_q, act_n_d;
  logic [BGWIDTH-1:0]   bg_q, bg_d;
  logic [BAWIDTH-1:0]   ba_q, ba_d;
  logic [ADDRWIDTH-1:0] a_q, a_d;
  logic                 req_ready_q, req_ready_d;
  logic                 busy_q, busy_d;

  logic [IW-1:0]        w_req_idx;
  logic [IW-1:0]        w_lat_idx;
  logic                 w_accept;
  logic                 w_last;

  assign w_req_idx = {req_bg, req_ba};
  assign w_lat_idx = {lat_bg_q, lat_ba_q};
  assign w_accept  = req_valid & req_ready_q;
  assign w_last    = (cnt_q == CW'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_wr_d  = lat_wr_q;
    lat_bg_d  = lat_bg_q;
    lat_ba_d  = lat_ba_q;
    lat_row_d = lat_row_q;
    lat_col_d = lat_col_q;
    open_d    = open_q;
    row_tbl_d = row_tbl_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          lat_wr_d  = req_wr;
          lat_bg_d  = req_bg;
          lat_ba_d  = req_ba;
          lat_row_d = req_row;
          lat_col_d = req_col;
          if (open_q[w_req_idx]) begin
            if (row_tbl_q[w_req_idx] == req_row) begin
              state_d = S_CAS;
              cnt_d   = CW'(BL);
            end else begin
              state_d = S_PRE;
              cnt_d   = CW'(TRP);
            end
          end else begin
            state_d = S_ACT;
            cnt_d   = CW'(TRCD);
          end
        end
      end
      // The counter covers the command cycle plus its wait; a load of 1 skips the wait state.
      S_PRE, S_PRE_WAIT: begin
        if (state_q == S_PRE) open_d[w_lat_idx] = 1'b0;
        if (w_last) begin
          state_d = S_ACT;
          cnt_d   = CW'(TRCD);
        end else begin
          state_d = S_PRE_WAIT;
          cnt_d   = cnt_q - CW'(1);
        end
      end
      S_ACT, S_ACT_WAIT: begin
        if (state_q == S_ACT) begin
          open_d[w_lat_idx]    = 1'b1;
          row_tbl_d[w_lat_idx] = lat_row_q;
        end
        if (w_last) begin
          state_d = S_CAS;
          cnt_d   = CW'(BL);
        end else begin
          state_d = S_ACT_WAIT;
          cnt_d   = cnt_q - CW'(1);
        end
      end
      S_CAS, S_BURST: begin
        if (w_last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_BURST;
          cnt_d   = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin image is built from the current state so each command lands one cycle after state entry.
  always_comb begin
    cke_d   = 1'b1;
    cs_n_d  = 1'b1;
    act_n_d = 1'b1;
    bg_d    = '0;
    ba_d    = '0;
    a_d     = '0;
    case (state_q)
      S_PRE: begin
        cs_n_d     = 1'b0;
        bg_d       = lat_bg_q;
        ba_d       = lat_ba_q;
        a_d[CAS_B] = 1'b1;
      end
      S_ACT: begin
        cs_n_d  = 1'b0;
        act_n_d = 1'b0;
        bg_d    = lat_bg_q;
        ba_d    = lat_ba_q;
        a_d     = lat_row_q;
      end
      S_CAS: begin
        cs_n_d              = 1'b0;
        bg_d                = lat_bg_q;
        ba_d                = lat_ba_q;
        a_d[RAS_B]          = 1'b1;
        a_d[WE_B]           = ~lat_wr_q;
        a_d[COLWIDTH-1:0]   = lat_col_q;
      end
      default: ;
    endcase
    req_ready_d = (state_d == S_IDLE) & cke_q;
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lat_wr_q    <= 1'b0;
      lat_bg_q    <= '0;
      lat_ba_q    <= '0;
      lat_row_q   <= '0;
      lat_col_q   <= '0;
      open_q      <= '0;
      for (int i = 0; i < NBANK; i++) row_tbl_q[i] <= '0;
      cke_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      act_n_q     <= 1'b1;
      bg_q        <= '0;
      ba_q        <= '0;
      a_q         <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_wr_q    <= lat_wr_d;
      lat_bg_q    <= lat_bg_d;
      lat_ba_q    <= lat_ba_d;
      lat_row_q   <= lat_row_d;
      lat_col_q   <= lat_col_d;
      open_q      <= open_d;
      row_tbl_q   <= row_tbl_d;
      cke_q       <= cke_d;
      cs_n_q      <= cs_n_d;
      act_n_q     <= act_n_d;
      bg_q        <= bg_d;
      ba_q        <= ba_d;
      a_q         <= a_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cke       = cke_q;
  assign cs_n      = cs_n_q;
  assign act_n     = act_n_q;
  assign bg        = bg_q;
  assign ba        = ba_q;
  assign A         = a_q;
  assign req_ready = req_ready_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr4_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ddr4_cmd_sequencer : directed bench for the DDR4 command sequencer
// Rev 1.0
// ============================================================================
module tb_ddr4_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_bg = '0;
  logic [1:0]  req_ba = '0;
  logic [16:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        cke, cs_n, act_n, busy;
  logic [1:0]  bg, ba;
  logic [16:0] A;

  int checks   = 0;
  int failures = 0;

  logic [22:0] pins;
  assign pins = {cs_n, act_n, bg, ba, A};

  localparam logic [22:0] NOP = {1'b1, 1'b1, 2'd0, 2'd0, 17'h00000};

  ddr4_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .cke(cke), .cs_n(cs_n), .act_n(act_n), .bg(bg), .ba(ba), .A(A),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for req_ready, then presents one request for exactly one accepting edge.
  task automatic issue(input logic wr, input logic [1:0] tbg, input logic [1:0] tba,
                       input logic [16:0] trow, input logic [9:0] tcol);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready_timeout req_ready=%b required 1", req_ready);
    end
    req_wr    = wr;
    req_bg    = tbg;
    req_ba    = tba;
    req_row   = trow;
    req_col   = tcol;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] obs;
    logic [25:0] exp;
    exp = {1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 17'h0, 1'b0, 1'b0};
    @(posedge clk);
    #3;
    rst = 1'b1;
    #2;
    obs = {cke, cs_n, act_n, bg, ba, A, req_ready, busy};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_async outputs=%h required %h", obs, exp);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({cke, req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL reset_cke_rise cke,ready=%b required 10", {cke, req_ready});
    end
    tick();
    checks++;
    if ({cke, req_ready, busy, pins} !== {1'b1, 1'b1, 1'b0, NOP}) begin
      failures++;
      $display("FAIL reset_ready cke,ready,busy,pins=%h required %h",
               {cke, req_ready, busy, pins}, {1'b1, 1'b1, 1'b0, NOP});
    end
  endtask

  task automatic test_write_closed();
    logic [22:0] exp;
    issue(1'b1, 2'd1, 2'd1, 17'd1, 10'd8);
    checks++;
    if ({req_ready, busy, pins} !== {1'b0, 1'b1, NOP}) begin
      failures++;
      $display("FAIL wr_closed_accept ready,busy,pins=%h required %h",
               {req_ready, busy, pins}, {1'b0, 1'b1, NOP});
    end
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp = NOP;
      if (i == 1) exp = {1'b0, 1'b0, 2'd1, 2'd1, 17'h00001};
      if (i == 5) exp = {1'b0, 1'b1, 2'd1, 2'd1, 17'h10008};
      checks++;
      if ({cke, pins} !== {1'b1, exp}) begin
        failures++;
        $display("FAIL wr_closed_pins[%0d] pins=%h required %h", i, pins, exp);
      end
      checks++;
      if ({req_ready, busy} !== {i == 12, i != 12}) begin
        failures++;
        $display("FAIL wr_closed_ready[%0d] ready,busy=%b required %b", i,
                 {req_ready, busy}, {i == 12, i != 12});
      end
    end
  endtask

  task automatic test_read_hit();
    logic [22:0] exp;
    int          busy_cycles;
    issue(1'b0, 2'd1, 2'd1, 17'd1, 10'd8);
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (busy === 1'b1) busy_cycles++;
      exp = (i == 1) ? {1'b0, 1'b1, 2'd1, 2'd1, 17'h14008} : NOP;
      checks++;
      if (pins !== exp) begin
        failures++;
        $display("FAIL rd_hit_pins[%0d] pins=%h required %h", i, pins, exp);
      end
    end
    checks++;
    if (busy_cycles != 8 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd_hit_busy busy_cycles=%0d ready=%b required 8 and 1",
               busy_cycles, req_ready);
    end
  endtask

  task automatic test_row_miss();
    logic [22:0] exp;
    issue(1'b0, 2'd1, 2'd1, 17'd2, 10'd3);
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp = NOP;
      if (i == 1) exp = {1'b0, 1'b1, 2'd1, 2'd1, 17'h08000};
      if (i == 5) exp = {1'b0, 1'b0, 2'd1, 2'd1, 17'h00002};
      if (i == 9) exp = {1'b0, 1'b1, 2'd1, 2'd1, 17'h14003};
      checks++;
      if ({req_ready, pins} !== {i == 16, exp}) begin
        failures++;
        $display("FAIL row_miss[%0d] ready,pins=%h required %h", i,
                 {req_ready, pins}, {i == 16, exp});
      end
    end
  endtask

  task automatic test_other_bank();
    logic [22:0] exp;
    issue(1'b0, 2'd0, 2'd2, 17'd5, 10'd0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp = NOP;
      if (i == 1) exp = {1'b0, 1'b0, 2'd0, 2'd2, 17'h00005};
      if (i == 5) exp = {1'b0, 1'b1, 2'd0, 2'd2, 17'h14000};
      checks++;
      if ({req_ready, pins} !== {i == 12, exp}) begin
        failures++;
        $display("FAIL other_bank[%0d] ready,pins=%h required %h", i,
                 {req_ready, pins}, {i == 12, exp});
      end
    end
    issue(1'b1, 2'd1, 2'd1, 17'd2, 10'h3ff);
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i == 1) ? {1'b0, 1'b1, 2'd1, 2'd1, 17'h103ff} : NOP;
      checks++;
      if ({req_ready, pins} !== {i == 8, exp}) begin
        failures++;
        $display("FAIL kept_open_hit[%0d] ready,pins=%h required %h", i,
                 {req_ready, pins}, {i == 8, exp});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [22:0] exp;
    logic [25:0] exp_rst;
    exp_rst = {1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 17'h0, 1'b0, 1'b0};
    issue(1'b0, 2'd2, 2'd3, 17'd7, 10'd4);
    tick();
    checks++;
    if (pins !== {1'b0, 1'b0, 2'd2, 2'd3, 17'h00007}) begin
      failures++;
      $display("FAIL mid_first_act pins=%h required %h", pins,
               {1'b0, 1'b0, 2'd2, 2'd3, 17'h00007});
    end
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({cke, cs_n, act_n, bg, ba, A, req_ready, busy} !== exp_rst) begin
      failures++;
      $display("FAIL mid_reset outputs=%h required %h",
               {cke, cs_n, act_n, bg, ba, A, req_ready, busy}, exp_rst);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if ({cke, req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL mid_cke_rise cke,ready=%b required 10", {cke, req_ready});
    end
    issue(1'b0, 2'd2, 2'd3, 17'd7, 10'd4);
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp = NOP;
      if (i == 1) exp = {1'b0, 1'b0, 2'd2, 2'd3, 17'h00007};
      if (i == 5) exp = {1'b0, 1'b1, 2'd2, 2'd3, 17'h14004};
      checks++;
      if ({req_ready, pins} !== {i == 12, exp}) begin
        failures++;
        $display("FAIL mid_resend[%0d] ready,pins=%h required %h", i,
                 {req_ready, pins}, {i == 12, exp});
      end
    end
    // Bank 1/1 was open before the reset; it must now be reopened with ACT.
    issue(1'b0, 2'd1, 2'd1, 17'd2, 10'd1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp = NOP;
      if (i == 1) exp = {1'b0, 1'b0, 2'd1, 2'd1, 17'h00002};
      if (i == 5) exp = {1'b0, 1'b1, 2'd1, 2'd1, 17'h14001};
      checks++;
      if ({req_ready, pins} !== {i == 12, exp}) begin
        failures++;
        $display("FAIL mid_cleared_table[%0d] ready,pins=%h required %h", i,
                 {req_ready, pins}, {i == 12, exp});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_closed();
    test_read_hit();
    test_row_miss();
    test_other_bank();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
